// File: rtl/pixrd_pkg.sv
// Shared types and helpers for the pixel readout arbiter.
package pixrd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WAIT
  } state_t;

  localparam int MAX_NPIX = 256;

  // Result width covers a full 256-pixel group (0..256).
  function automatic logic [8:0] popcount(input logic [MAX_NPIX-1:0] v);
    logic [8:0] c;
    c = '0;
    for (int i = 0; i < MAX_NPIX; i++) begin
      c = c + 9'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/pixel_prio_tree.sv
// Masked priority encoder built as a binary tree of 2-input nodes; the lower
// index wins at every node, so the root reports the lowest eligible request.
module pixel_prio_tree #(
  parameter  int NPIX = 16,
  localparam int AW   = $clog2(NPIX)
) (
  input  logic [NPIX-1:0] req,
  input  logic [NPIX-1:0] mask,
  output logic [AW-1:0]   idx,
  output logic            found
);

  for (genvar l = 0; l <= AW; l++) begin : g_lvl
    localparam int N = NPIX >> l;
    logic [N-1:0]         f;
    logic [N-1:0][AW-1:0] ix;

    if (l == 0) begin : g_leaf
      for (genvar j = 0; j < N; j++) begin : g_in
        assign f[j]  = req[j] & mask[j];
        assign ix[j] = AW'(j);
      end
    end else begin : g_node
      for (genvar j = 0; j < N; j++) begin : g_pair
        assign f[j]  = g_lvl[l-1].f[2*j] | g_lvl[l-1].f[2*j+1];
        assign ix[j] = g_lvl[l-1].f[2*j] ? g_lvl[l-1].ix[2*j] : g_lvl[l-1].ix[2*j+1];
      end
    end
  end

  assign idx   = g_lvl[AW].ix[0];
  assign found = g_lvl[AW].f[0];

endmodule

// File: rtl/pixel_readout_arbiter.sv
// Frame-based pixel readout arbiter: snapshots hit flags, then drains one
// address per VALID/READY handshake in fixed or round-robin order.
module pixel_readout_arbiter
  import pixrd_pkg::*;
#(
  parameter  int NPIX = 16,
  parameter  int RR   = 0,
  localparam int AW   = $clog2(NPIX)
) (
  input  logic            CLKIN,
  input  logic            RSTN,
  input  logic            EN,
  input  logic [NPIX-1:0] HIT,
  output logic [NPIX-1:0] CLEAR,
  output logic [AW-1:0]   ADDR,
  output logic            VALID,
  input  logic            READY,
  output logic            BUSY,
  output logic            FRAME_END,
  output logic [AW:0]     NHIT
);

  state_t          state;
  logic [NPIX-1:0] pend;
  logic [AW-1:0]   ptr;
  logic [NPIX-1:0] mask;
  logic [NPIX-1:0] acc_1h;
  logic [AW-1:0]   m_idx, u_idx, win;
  logic            m_found, u_found;

  // Thermometer mask: bits at or above the round-robin pointer are eligible.
  assign mask   = (RR != 0) ? ~((NPIX'(1) << ptr) - NPIX'(1)) : '1;
  assign acc_1h = NPIX'(1) << ADDR;
  assign win    = m_found ? m_idx : u_idx;
  assign BUSY   = (state != IDLE);

  pixel_prio_tree #(.NPIX(NPIX)) u_masked (
    .req   (pend),
    .mask  (mask),
    .idx   (m_idx),
    .found (m_found)
  );

  pixel_prio_tree #(.NPIX(NPIX)) u_unmasked (
    .req   (pend),
    .mask  ({NPIX{1'b1}}),
    .idx   (u_idx),
    .found (u_found)
  );

  always_ff @(posedge CLKIN or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      pend      <= '0;
      ptr       <= '0;
      CLEAR     <= '0;
      ADDR      <= '0;
      VALID     <= 1'b0;
      FRAME_END <= 1'b0;
      NHIT      <= '0;
    end else begin
      CLEAR     <= '0;
      FRAME_END <= 1'b0;
      case (state)
        IDLE: begin
          if (EN && (|HIT)) begin
            pend  <= HIT;
            NHIT  <= (AW+1)'(popcount(MAX_NPIX'(HIT)));
            state <= GRANT;
          end
        end
        GRANT: begin
          if (u_found) begin
            ADDR  <= win;
            VALID <= 1'b1;
            state <= WAIT;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (VALID && READY) begin
            VALID      <= 1'b0;
            pend[ADDR] <= 1'b0;
            CLEAR      <= acc_1h;
            if (RR != 0) ptr <= ADDR + AW'(1);
            if (|(pend & ~acc_1h)) begin
              state <= GRANT;
            end else begin
              state     <= IDLE;
              FRAME_END <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
